// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM controller for the multi-cycle processor datapath
module multicycle_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           func,
  input  logic [3:0]           Cond,
  input  logic [3:0]           ALU_Flag,
  output logic                 PC_Write,
  output logic                 IR_Write,
  output logic                 Adr_Src,
  output logic                 Mem_Write,
  output logic                 Reg_Write,
  output logic [1:0]           Result_Src,
  output logic [1:0]           ALU_SrcA,
  output logic [1:0]           ALU_SrcB,
  output logic [2:0]           ALU_Control,
  output logic [3:0]           CPSR,
  output logic [3:0]           State,
  output logic [CNT_WIDTH-1:0] Instr_Count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MOV = 3'b100;

  state_t state_q;
  state_t state_d;

  logic [3:0] cmd;
  logic       imm_bit;
  logic       s_bit;
  logic       is_cmp;
  logic       cmd_valid;
  logic [2:0] cmd_alu;
  logic       cond_ex;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       in_exec;
  logic       retire;
  logic       cpsr_load;

  logic       pc_write_raw;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;

  assign cmd     = func[4:1];
  assign imm_bit = func[5];
  assign s_bit   = func[0];
  assign is_cmp  = (cmd == CMD_CMP);

  assign {flag_n, flag_z, flag_c, flag_v} = CPSR;

  always_comb begin
    cmd_valid = 1'b1;
    cmd_alu   = ALU_ADD;
    case (cmd)
      CMD_ADD: cmd_alu = ALU_ADD;
      CMD_SUB: cmd_alu = ALU_SUB;
      CMD_CMP: cmd_alu = ALU_SUB;
      CMD_AND: cmd_alu = ALU_AND;
      CMD_ORR: cmd_alu = ALU_ORR;
      CMD_MOV: cmd_alu = ALU_MOV;
      default: cmd_valid = 1'b0;
    endcase
  end

  // Condition is judged against the registered flags, never the live ALU flags.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        // Undefined cmd only matters for data-processing; elsewhere func holds offsets.
        if (!cond_ex)                         state_d = FETCH;
        else if (Op == 2'b11)                 state_d = FETCH;
        else if (Op == 2'b00 && !cmd_valid)   state_d = FETCH;
        else if (Op == 2'b01)                 state_d = MEMADR;
        else if (Op == 2'b00)                 state_d = imm_bit ? EXECI : EXECR;
        else                                  state_d = BRANCH;
      end
      MEMADR:   state_d = s_bit ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECR:    state_d = is_cmp ? FETCH : ALUWB;
      EXECI:    state_d = is_cmp ? FETCH : ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    Adr_Src       = 1'b0;
    Result_Src    = 2'b00;
    ALU_SrcA      = 2'b00;
    ALU_SrcB      = 2'b00;
    ALU_Control   = ALU_ADD;
    case (state_q)
      FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        ALU_SrcA     = 2'b01;
        ALU_SrcB     = 2'b10;
        Result_Src   = 2'b10;
      end
      DECODE: begin
        ALU_SrcA   = 2'b01;
        ALU_SrcB   = 2'b10;
        Result_Src = 2'b10;
      end
      MEMADR: begin
        ALU_SrcA = 2'b00;
        ALU_SrcB = 2'b01;
      end
      MEMREAD: Adr_Src = 1'b1;
      MEMWB: begin
        Result_Src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        Adr_Src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECR: ALU_Control = cmd_alu;
      EXECI: begin
        ALU_SrcB    = 2'b01;
        ALU_Control = cmd_alu;
      end
      ALUWB: reg_write_raw = 1'b1;
      BRANCH: begin
        ALU_SrcA     = 2'b10;
        ALU_SrcB     = 2'b01;
        Result_Src   = 2'b10;
        pc_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural writes are suppressed for the whole time reset is held.
  assign PC_Write  = pc_write_raw  & ~reset;
  assign IR_Write  = ir_write_raw  & ~reset;
  assign Mem_Write = mem_write_raw & ~reset;
  assign Reg_Write = reg_write_raw & ~reset;

  assign in_exec   = (state_q == EXECR) || (state_q == EXECI);
  assign cpsr_load = in_exec && (s_bit || is_cmp);

  // Illegal codes 10-15 also fall to FETCH but never retire an instruction.
  always_comb begin
    retire = 1'b0;
    if (state_d == FETCH) begin
      case (state_q)
        DECODE, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      CPSR        <= 4'b0000;
      Instr_Count <= '0;
    end else begin
      state_q <= state_d;
      if (cpsr_load) CPSR <= ALU_Flag;
      if (retire) Instr_Count <= Instr_Count + CNT_WIDTH'(1);
    end
  end

  assign State = state_q;

endmodule
